// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types and widths for the two-input packet arbiter
//
// Purpose : state encoding and datapath/counter widths shared by the arbiter
//           top module, its stream interface and the round-robin picker.
package axis_arb_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;
  localparam int BEAT_CTR_W  = 10;

  // DRAIN is only ever entered when AXIS_ARB_TRIM_EN is defined.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// rtl/axis_pkt_arbiter_if.sv - one AXI-Stream link (tdata/tkeep/tlast/tvalid/tready)
//
// Purpose : bundles one stream hop so the arbiter sees sources and sink as
//           single ports.
// Modports: master - drives tdata/tkeep/tlast/tvalid, samples tready
//           slave  - samples tdata/tkeep/tlast/tvalid, drives tready
interface axis_pkt_arbiter_if;
  import axis_arb_pkg::*;

  logic [AXIS_DATA_W-1:0] tdata;
  logic [AXIS_KEEP_W-1:0] tkeep;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);

endinterface

// File: rtl/axis_pkt_arbiter_rr_grant2.sv
// rtl/axis_pkt_arbiter_rr_grant2.sv - combinational two-requester round-robin picker
//
// Purpose : picks one requester; on contention the one that was not granted
//           last time wins.
// Ports   : req[1:0] in  - request per source
//           last     in  - index of the previously granted source
//           gnt[1:0] out - one-hot grant, 2'b00 when nobody requests
module rr_grant2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// rtl/axis_pkt_arbiter.sv - two-source AXI-Stream packet arbiter with optional length trim
//
// Purpose : shares one 64-bit stream between two packet sources. Grant is
//           decided in an IDLE bubble cycle and held until the packet's
//           last beat is accepted. Build macro AXIS_ARB_TRIM_EN enables the
//           length limiter: TLAST is forced at MAX_BEATS and the rest of the
//           source packet is drained and discarded.
// Ports   : clk, rst_n          - clock, asynchronous active-low reset
//           s0_axis, s1_axis    - source streams (slave modport)
//           m0_axis             - downstream stream (master modport)
//           grant[1:0]          - one-hot active source, 00 when idle
//           trim_event          - one-cycle pulse when a packet is truncated
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int MAX_BEATS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  axis_pkt_arbiter_if.slave         s0_axis,
  axis_pkt_arbiter_if.slave         s1_axis,
  axis_pkt_arbiter_if.master        m0_axis,
  output logic [1:0]                grant,
  output logic                      trim_event
);

  localparam logic [BEAT_CTR_W-1:0] LAST_BEAT_IDX = BEAT_CTR_W'(MAX_BEATS - 1);

  arb_state_e             state_q, state_d;
  logic                   last_q, last_d;
  logic [BEAT_CTR_W-1:0]  beat_ctr_q, beat_ctr_d;
  logic [1:0]             grant_q, grant_d;
  logic                   trim_event_q, trim_event_d;

  logic [1:0]             req, rr_gnt;
  logic [AXIS_DATA_W-1:0] src_tdata;
  logic [AXIS_KEEP_W-1:0] src_tkeep;
  logic                   src_tlast, src_tvalid, src_tready;
  logic                   at_limit, beat;

  assign req = {s1_axis.tvalid, s0_axis.tvalid};

  rr_grant2 u_rr_grant2 (
    .req  (req),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  // last_q always holds the most recent grant index, so it doubles as the
  // source select; in IDLE the mux output is ignored because TVALID is 0.
  always_comb begin
    if (last_q) begin
      src_tdata  = s1_axis.tdata;
      src_tkeep  = s1_axis.tkeep;
      src_tlast  = s1_axis.tlast;
      src_tvalid = s1_axis.tvalid;
    end else begin
      src_tdata  = s0_axis.tdata;
      src_tkeep  = s0_axis.tkeep;
      src_tlast  = s0_axis.tlast;
      src_tvalid = s0_axis.tvalid;
    end
  end

`ifdef AXIS_ARB_TRIM_EN
  assign at_limit = (beat_ctr_q == LAST_BEAT_IDX);
`else
  // Limiter compiled out: the term is constant 0 and packets pass unmodified.
  assign at_limit = 1'b0 & (beat_ctr_q == LAST_BEAT_IDX);
`endif

  always_comb begin
    src_tready     = 1'b0;
    m0_axis.tvalid = 1'b0;
    case (state_q)
      PASS: begin
        src_tready     = m0_axis.tready;
        m0_axis.tvalid = src_tvalid;
      end
`ifdef AXIS_ARB_TRIM_EN
      DRAIN: src_tready = 1'b1;
`endif
      default: ;
    endcase
  end

  assign m0_axis.tdata  = src_tdata;
  assign m0_axis.tkeep  = src_tkeep;
  assign m0_axis.tlast  = src_tlast | at_limit;
  assign s0_axis.tready = src_tready & grant_q[0];
  assign s1_axis.tready = src_tready & grant_q[1];
  assign beat           = m0_axis.tvalid & m0_axis.tready;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    beat_ctr_d   = beat_ctr_q;
    grant_d      = grant_q;
    trim_event_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|rr_gnt) begin
          state_d    = PASS;
          grant_d    = rr_gnt;
          last_d     = rr_gnt[1];
          beat_ctr_d = '0;
        end
      end
      PASS: begin
        if (beat) begin
          beat_ctr_d = beat_ctr_q + BEAT_CTR_W'(1);
          if (m0_axis.tlast) begin
            state_d = IDLE;
            grant_d = 2'b00;
`ifdef AXIS_ARB_TRIM_EN
            // Forced last: keep the grant and swallow the source's tail.
            if (!src_tlast) begin
              state_d      = DRAIN;
              grant_d      = grant_q;
              trim_event_d = 1'b1;
            end
`endif
          end
        end
      end
`ifdef AXIS_ARB_TRIM_EN
      DRAIN: begin
        if (src_tvalid && src_tlast) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      beat_ctr_q   <= '0;
      grant_q      <= 2'b00;
      trim_event_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      beat_ctr_q   <= beat_ctr_d;
      grant_q      <= grant_d;
      trim_event_q <= trim_event_d;
    end
  end

  assign grant      = grant_q;
  assign trim_event = trim_event_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb/tb_axis_pkt_arbiter.sv - self-checking bench for axis_pkt_arbiter
module tb_axis_pkt_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] grant;
  logic       trim_event;
  int         checks;
  int         errors;

  axis_pkt_arbiter_if s0_axis ();
  axis_pkt_arbiter_if s1_axis ();
  axis_pkt_arbiter_if m0_axis ();

  axis_pkt_arbiter #(.MAX_BEATS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s0_axis    (s0_axis),
    .s1_axis    (s1_axis),
    .m0_axis    (m0_axis),
    .grant      (grant),
    .trim_event (trim_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        s0_v;
    logic        s0_l;
    logic [63:0] s0_d;
    logic        s1_v;
    logic        s1_l;
    logic [63:0] s1_d;
    logic        m_rdy;
    logic        e_v;
    logic        e_l;
    logic [63:0] e_d;
    logic [1:0]  e_g;
    logic        e_r0;
    logic        e_r1;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic s0v, input logic s0l, input logic [63:0] s0d,
                              input logic s1v, input logic s1l, input logic [63:0] s1d, input logic rdy,
                              input logic ev, input logic el, input logic [63:0] ed, input logic [1:0] eg,
                              input logic er0, input logic er1);
    vec_t v;
    v.rst_n = r;  v.s0_v = s0v; v.s0_l = s0l; v.s0_d = s0d;
    v.s1_v = s1v; v.s1_l = s1l; v.s1_d = s1d; v.m_rdy = rdy;
    v.e_v = ev;   v.e_l = el;   v.e_d = ed;   v.e_g = eg;
    v.e_r0 = er0; v.e_r1 = er1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_axis.tvalid = 1'b0; s0_axis.tlast = 1'b0; s0_axis.tdata = '0;
    s1_axis.tvalid = 1'b0; s1_axis.tlast = 1'b0; s1_axis.tdata = '0;
    m0_axis.tready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  localparam logic [63:0] A1 = 64'hAAAA_0000_0000_0001, A2 = 64'hAAAA_0000_0000_0002, A3 = 64'hAAAA_0000_0000_0003;
  localparam logic [63:0] B0 = 64'hBBBB_0000_0000_0000, B1 = 64'hBBBB_0000_0000_0001;
  localparam logic [63:0] B2 = 64'hBBBB_0000_0000_0002, B3 = 64'hBBBB_0000_0000_0003, B4 = 64'hBBBB_0000_0000_0004;
  localparam logic [63:0] C0 = 64'hCCCC_0000_0000_0000, C1 = 64'hCCCC_0000_0000_0001;
  localparam logic [63:0] C2 = 64'hCCCC_0000_0000_0002, C3 = 64'hCCCC_0000_0000_0003;
  localparam logic [63:0] E0 = 64'hEEEE_0000_0000_0000;

  initial begin
    checks = 0;
    errors = 0;
    s0_axis.tkeep = 8'hFF;
    s1_axis.tkeep = 8'h0F;
    idle_inputs();
    rst_n = 1'b0;

    // S0-only 3-beat packet, then S0/S1 alternating 2-beat packets from reset.
    vq.push_back(mk(0, 0,0,0,  0,0,0,  1, 0,0,0,  2'b00, 0,0));
    vq.push_back(mk(1, 1,0,A1, 0,0,0,  1, 0,0,0,  2'b00, 0,0));
    vq.push_back(mk(1, 1,0,A1, 0,0,0,  1, 1,0,A1, 2'b01, 1,0));
    vq.push_back(mk(1, 1,0,A2, 0,0,0,  1, 1,0,A2, 2'b01, 1,0));
    vq.push_back(mk(1, 1,1,A3, 0,0,0,  1, 1,1,A3, 2'b01, 1,0));
    vq.push_back(mk(1, 0,0,0,  0,0,0,  1, 0,0,0,  2'b00, 0,0));
    vq.push_back(mk(0, 1,0,B0, 1,0,C0, 1, 0,0,0,  2'b00, 0,0));
    vq.push_back(mk(1, 1,0,B0, 1,0,C0, 1, 0,0,0,  2'b00, 0,0));
    vq.push_back(mk(1, 1,0,B0, 1,0,C0, 1, 1,0,B0, 2'b01, 1,0));
    vq.push_back(mk(1, 1,1,B1, 1,0,C0, 1, 1,1,B1, 2'b01, 1,0));
    vq.push_back(mk(1, 1,0,B2, 1,0,C0, 1, 0,0,0,  2'b00, 0,0));
    vq.push_back(mk(1, 1,0,B2, 1,0,C0, 1, 1,0,C0, 2'b10, 0,1));
    vq.push_back(mk(1, 1,0,B2, 1,1,C1, 1, 1,1,C1, 2'b10, 0,1));
    vq.push_back(mk(1, 1,0,B2, 1,0,C2, 1, 0,0,0,  2'b00, 0,0));
    vq.push_back(mk(1, 1,0,B2, 1,0,C2, 1, 1,0,B2, 2'b01, 1,0));
    vq.push_back(mk(1, 1,1,B3, 1,0,C2, 1, 1,1,B3, 2'b01, 1,0));
    vq.push_back(mk(1, 1,0,B4, 1,0,C2, 1, 0,0,0,  2'b00, 0,0));
    vq.push_back(mk(1, 1,0,B4, 1,0,C2, 1, 1,0,C2, 2'b10, 0,1));
    vq.push_back(mk(1, 1,0,B4, 1,1,C3, 1, 1,1,C3, 2'b10, 0,1));

    tick();
    foreach (vq[i]) begin
      rst_n = vq[i].rst_n;
      s0_axis.tvalid = vq[i].s0_v; s0_axis.tlast = vq[i].s0_l; s0_axis.tdata = vq[i].s0_d;
      s1_axis.tvalid = vq[i].s1_v; s1_axis.tlast = vq[i].s1_l; s1_axis.tdata = vq[i].s1_d;
      m0_axis.tready = vq[i].m_rdy;
      #3;
      chk($sformatf("vec%0d_tvalid", i), 64'(m0_axis.tvalid), 64'(vq[i].e_v));
      chk($sformatf("vec%0d_grant", i), 64'(grant), 64'(vq[i].e_g));
      chk($sformatf("vec%0d_s0_tready", i), 64'(s0_axis.tready), 64'(vq[i].e_r0));
      chk($sformatf("vec%0d_s1_tready", i), 64'(s1_axis.tready), 64'(vq[i].e_r1));
      chk($sformatf("vec%0d_trim_event", i), 64'(trim_event), 64'(0));
      if (vq[i].e_v) begin
        chk($sformatf("vec%0d_tdata", i), m0_axis.tdata, vq[i].e_d);
        chk($sformatf("vec%0d_tlast", i), 64'(m0_axis.tlast), 64'(vq[i].e_l));
        chk($sformatf("vec%0d_tkeep", i), 64'(m0_axis.tkeep), vq[i].e_g[1] ? 64'h0F : 64'hFF);
      end
      tick();
    end

    // Backpressure: downstream stalls 4 cycles after the first beat of a 4-beat S0 packet.
    begin
      int idx, outn, stall;
      idx = 0; outn = 0; stall = 0;
      do_reset();
      for (int cyc = 0; cyc < 40 && outn < 4; cyc++) begin
        s0_axis.tvalid = (idx < 4);
        s0_axis.tdata  = 64'hD000 + 64'(idx);
        s0_axis.tlast  = (idx == 3);
        m0_axis.tready = !(outn == 1 && stall < 4);
        #3;
        if (!m0_axis.tready) begin
          stall++;
          chk("bp_hold_tvalid", 64'(m0_axis.tvalid), 64'(1));
          chk("bp_hold_tdata", m0_axis.tdata, 64'hD001);
          chk("bp_src_tready", 64'(s0_axis.tready), 64'(0));
          chk("bp_beat_ctr", 64'(dut.beat_ctr_q), 64'(1));
        end
        if (m0_axis.tvalid && m0_axis.tready) begin
          chk("bp_beat_data", m0_axis.tdata, 64'hD000 + 64'(outn));
          chk("bp_beat_last", 64'(m0_axis.tlast), 64'(outn == 3));
          outn++;
        end
        if (s0_axis.tvalid && s0_axis.tready) idx++;
        tick();
      end
      chk("bp_beats_out", 64'(outn), 64'(4));
      chk("bp_src_consumed", 64'(idx), 64'(4));
      chk("bp_stall_cycles", 64'(stall), 64'(4));
    end

    // 12-beat S1 packet: trimmed to 8 with a 4-beat drain, or passed whole.
    begin
      int idx, outn, last_pos, trims, drained;
      idx = 0; outn = 0; last_pos = 0; trims = 0; drained = 0;
      do_reset();
      for (int cyc = 0; cyc < 60; cyc++) begin
        s1_axis.tvalid = (idx < 12);
        s1_axis.tdata  = 64'hC100 + 64'(idx);
        s1_axis.tlast  = (idx == 11);
        #3;
        if (trim_event) trims++;
        if (m0_axis.tvalid && m0_axis.tready) begin
          chk("len_beat_data", m0_axis.tdata, 64'hC100 + 64'(outn));
          outn++;
          if (m0_axis.tlast && last_pos == 0) last_pos = outn;
        end
        if (s1_axis.tvalid && s1_axis.tready && !m0_axis.tvalid) drained++;
        if (s1_axis.tvalid && s1_axis.tready) idx++;
        tick();
        if (idx == 12 && cyc > 20) break;
      end
      #3;
      chk("len_src_consumed", 64'(idx), 64'(12));
      chk("len_grant_after", 64'(grant), 64'(0));
`ifdef AXIS_ARB_TRIM_EN
      chk("trim_beats_out", 64'(outn), 64'(8));
      chk("trim_last_pos", 64'(last_pos), 64'(8));
      chk("trim_event_cycles", 64'(trims), 64'(1));
      chk("trim_drained", 64'(drained), 64'(4));
`else
      chk("pass_beats_out", 64'(outn), 64'(12));
      chk("pass_last_pos", 64'(last_pos), 64'(12));
      chk("pass_trim_event_cycles", 64'(trims), 64'(0));
      chk("pass_drained", 64'(drained), 64'(0));
`endif
      tick();
    end

    // Exactly 8-beat S0 packet with S1 waiting: no trim, S1 follows after one idle cycle.
    begin
      int i0, i1, n0, lasts0, trims, cyc_s0_last, cyc_s1;
      i0 = 0; i1 = 0; n0 = 0; lasts0 = 0; trims = 0; cyc_s0_last = -100; cyc_s1 = -1;
      do_reset();
      for (int cyc = 0; cyc < 40 && !(i0 == 8 && i1 == 1); cyc++) begin
        s0_axis.tvalid = (i0 < 8);
        s0_axis.tdata  = 64'h5000 + 64'(i0);
        s0_axis.tlast  = (i0 == 7);
        s1_axis.tvalid = (i1 < 1);
        s1_axis.tdata  = 64'h6000;
        s1_axis.tlast  = 1'b1;
        #3;
        if (trim_event) trims++;
        if (m0_axis.tvalid && m0_axis.tready) begin
          if (m0_axis.tdata == 64'h6000) cyc_s1 = cyc;
          else begin
            n0++;
            if (m0_axis.tlast) begin lasts0++; cyc_s0_last = cyc; end
          end
        end
        if (s0_axis.tvalid && s0_axis.tready) i0++;
        if (s1_axis.tvalid && s1_axis.tready) i1++;
        tick();
      end
      #3;
      if (trim_event) trims++;
      chk("exact8_done", 64'({i0 == 8, i1 == 1}), 64'b11);
      chk("exact8_beats", 64'(n0), 64'(8));
      chk("exact8_tlast_count", 64'(lasts0), 64'(1));
      chk("exact8_trim_event", 64'(trims), 64'(0));
      chk("exact8_gap", 64'(cyc_s1 - cyc_s0_last), 64'(2));
      tick();
    end

    // Reset pulsed during beat 2 of an S1 packet.
    begin
      do_reset();
      s1_axis.tvalid = 1'b1; s1_axis.tdata = C0; s1_axis.tlast = 1'b0;
      tick();
      tick();
      s1_axis.tdata = C1;
      #2;
      chk("rst_mid_pre_tvalid", 64'(m0_axis.tvalid), 64'(1));
      chk("rst_mid_pre_grant", 64'(grant), 64'(2'b10));
      rst_n = 1'b0;
      #1;
      chk("rst_mid_tvalid", 64'(m0_axis.tvalid), 64'(0));
      chk("rst_mid_s1_tready", 64'(s1_axis.tready), 64'(0));
      chk("rst_mid_s0_tready", 64'(s0_axis.tready), 64'(0));
      chk("rst_mid_grant", 64'(grant), 64'(0));
      tick();
      rst_n = 1'b1;
      s0_axis.tvalid = 1'b1; s0_axis.tdata = E0; s0_axis.tlast = 1'b1;
      #3;
      chk("rst_after_idle_tvalid", 64'(m0_axis.tvalid), 64'(0));
      tick();
      #3;
      chk("rst_after_grant", 64'(grant), 64'(2'b01));
      chk("rst_after_tdata", m0_axis.tdata, E0);
      chk("rst_after_tvalid", 64'(m0_axis.tvalid), 64'(1));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Two-input AXI-Stream packet arbiter that shares one 64-bit downstream stream path between two packet sources. Round-robin grant is taken at packet boundaries and held until the granted packet's TLAST is accepted. An optional length limiter forces TLAST at a configured beat count and discards the packet's remaining beats. The block sits in front of the stream processing path, upstream of anything that requires whole, length-bounded packets.

## Interface
- MAX_BEATS, 8: maximum forwarded beats per packet (trim build only); legal range 1..1023
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- S0_AXIS_TDATA / S1_AXIS_TDATA  in  64  source data
- S0_AXIS_TKEEP / S1_AXIS_TKEEP  in  8  byte enables
- S0_AXIS_TLAST / S1_AXIS_TLAST  in  1  end of packet
- S0_AXIS_TVALID / S1_AXIS_TVALID  in  1  source valid
- S0_AXIS_TREADY / S1_AXIS_TREADY  out  1  source ready
- M0_AXIS_TDATA  out  64  granted source data
- M0_AXIS_TKEEP  out  8  granted source keep
- M0_AXIS_TLAST  out  1  end of packet (source TLAST or forced)
- M0_AXIS_TVALID  out  1  output valid
- M0_AXIS_TREADY  in  1  downstream ready
- grant  out  2  one-hot active source; 2'b00 when idle
- trim_event  out  1  one-cycle pulse when a packet is truncated

## Operation
- States: IDLE, PASS, DRAIN (DRAIN reachable only in the trim build).
- IDLE: both S TREADY=0, M0_AXIS_TVALID=0, grant=00. If any S TVALID, register a grant and go to PASS.
- Round-robin: `last` register, reset value 1. With both sources valid, grant the source that is not `last`. With one source valid, grant that source. On grant, `last` is set to the granted index.
- PASS: M0 TDATA, TKEEP, TVALID and TLAST are combinational copies of the granted source. Granted S TREADY = M0_AXIS_TREADY. The other S TREADY = 0.
- A beat is counted when M0 TVALID and M0 TREADY are both high. `beat_ctr` is 10 bits, cleared when the FSM enters PASS.
- On a counted beat with M0 TLAST=1: go to IDLE, so the next grant is decided on the following cycle.
- The M0 TDATA/TKEEP mux keeps tracking the last grant while in IDLE; the value is don't-care because M0 TVALID=0.
- A grant is never changed mid-packet. A non-granted source may hold TVALID for any number of cycles without effect.

## Timing
- Reset (asynchronous assert, synchronous deassert to clk by the integrator): FSM=IDLE, `last`=1, beat_ctr=0, grant=00, trim_event=0, all TVALID/TREADY outputs 0.
- Data path latency is 0 cycles (combinational pass-through) while in PASS.
- Each packet carries a 1-cycle arbitration bubble (the IDLE cycle). Maximum throughput is N/(N+1) beats per cycle for N-beat packets.
- rst_n asserted mid-packet: outputs drop immediately and the partial packet is abandoned. After release, arbitration restarts with S0 priority.
- Single-beat packet (TLAST on the first beat): PASS lasts one accepted beat.

## Configuration
- AXIS_ARB_TRIM_EN defined:
  - In PASS, M0_AXIS_TLAST = source TLAST OR (beat_ctr == MAX_BEATS-1).
  - On a counted forced-last beat with source TLAST=0: go to DRAIN and pulse trim_event for 1 cycle.
  - DRAIN: M0 TVALID=0, granted S TREADY=1, and source beats are discarded. On an accepted source beat with TLAST=1, go to IDLE.
  - A source packet of exactly MAX_BEATS beats is not trimmed and does not pulse trim_event.
- AXIS_ARB_TRIM_EN undefined:
  - Packets are forwarded unmodified. MAX_BEATS is ignored, the DRAIN state is absent and trim_event is tied 0.
  - beat_ctr still counts and is kept as a debug value.

## Structure
- Shared package axis_arb_pkg holds:
  - the state enum (IDLE, PASS, DRAIN)
  - AXIS_DATA_W=64 and AXIS_KEEP_W=8
  - the beat counter width constant (10)
- Sub-module rr_grant2: combinational two-requester round-robin picker. Inputs are req[1:0] and last; output is a one-hot gnt[1:0]. The FSM, counter and muxes stay in the top module.

## Test plan
- S0 only, 3-beat packet, M0 TREADY=1 -> 1 idle cycle, then 3 output beats with TLAST on beat 3; grant=01 during PASS, 00 afterwards.
- S0 and S1 both continuously sending 2-beat packets from reset -> output packet order S0,S1,S0,S1; each packet preceded by exactly one TVALID=0 cycle.
- Backpressure: M0 TREADY low for 4 cycles mid-packet -> granted S TREADY low, output data held stable, beat_ctr unchanged, no beats lost or duplicated.
- Trim build, MAX_BEATS=8, 12-beat S1 packet -> 8 beats out, beat 8 TLAST=1, trim_event high for 1 cycle; 4 beats consumed with M0 TVALID=0; then IDLE.
- Trim build, MAX_BEATS=8, packet of exactly 8 beats -> no DRAIN and trim_event stays 0; next packet granted after one idle cycle.
- rst_n pulsed low during beat 2 of an S1 packet -> all valid/ready outputs 0 asynchronously; after release with both sources valid, S0 is granted first.
